// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RV32I multicycle controller: states, opcodes, ALU classes, immediate formats.
// The ILLEGAL state exists only when CU_ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

`ifdef CU_ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;
`else
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/control_unit_imm_decoder.sv
// Immediate format select from the opcode; purely combinational, I-format by default.
module control_unit_imm_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/control_unit_main_fsm.sv
// Multicycle RV32I main controller: fetch/decode/execute/memory/writeback sequencing with memory stall.
// CU_ILLEGAL_TRAP_EN traps unknown opcodes in a sticky ILLEGAL state; otherwise they run as NOPs.
module control_unit_main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic       illegal_instr,
`endif
    output logic [3:0] state_dbg
);

    state_t state;
    logic   pc_update;
    logic   branch;
    logic   ir_load;
    logic   rf_we;
    logic   dm_we;
    logic   done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECR;
                        OP_ITYPE:          state <= S_EXECI;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JAL;
`ifdef CU_ILLEGAL_TRAP_EN
                        default:           state <= S_ILLEGAL;
`else
                        default:           state <= S_FETCH;
`endif
                    endcase
                end
                S_MEMADR:   state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
`ifdef CU_ILLEGAL_TRAP_EN
                S_ILLEGAL:  state <= S_ILLEGAL;
`endif
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_load    = 1'b0;
        rf_we      = 1'b0;
        dm_we      = 1'b0;
        done       = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_load    = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
`ifndef CU_ILLEGAL_TRAP_EN
                done = !(op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL});
`endif
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                rf_we      = 1'b1;
                done       = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                dm_we   = 1'b1;
                done    = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_RTYPE;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_RTYPE;
            end
            S_ALUWB: begin
                rf_we = 1'b1;
                done  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_BRANCH;
                branch    = 1'b1;
                done      = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks every write enable so an aborted instruction cannot commit anything.
    assign pc_write   = !rst && (pc_update || (branch && branch_taken));
    assign ir_write   = !rst && ir_load;
    assign reg_write  = !rst && rf_we;
    assign mem_write  = !rst && dm_we;
    assign instr_done = !rst && done;
    assign state_dbg  = state;

`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal_instr = (state == S_ILLEGAL);
`endif

    control_unit_imm_decoder u_imm_decoder (
        .op      (op),
        .imm_src (imm_src)
    );

endmodule

// File: tb/tb_control_unit_main_fsm.sv
// Directed bench for control_unit_main_fsm: hand-computed per-cycle expectations for each instruction class.
// Builds with or without CU_ILLEGAL_TRAP_EN.
module tb_control_unit_main_fsm;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECR    = 4'd6;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_ILLEGAL  = 4'd11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       pc_write, ir_write, reg_write, mem_write, adr_src, instr_done;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, alu_op;
    logic [3:0] state_dbg;
`ifdef CU_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_unit_main_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .adr_src      (adr_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .result_src   (result_src),
        .imm_src      (imm_src),
        .alu_op       (alu_op),
        .instr_done   (instr_done),
`ifdef CU_ILLEGAL_TRAP_EN
        .illegal_instr(illegal_instr),
`endif
        .state_dbg    (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then settle before sampling outputs.
    task automatic cyc(input logic r, input logic [6:0] o, input logic mr, input logic bt);
        @(negedge clk);
        rst = r;
        op = o;
        mem_ready = mr;
        branch_taken = bt;
        #1;
    endtask

    // Packed enables {pc_write, ir_write, reg_write, mem_write, instr_done}.
    function automatic logic [4:0] en();
        return {pc_write, ir_write, reg_write, mem_write, instr_done};
    endfunction

    initial begin
        // Power-up reset
        cyc(1'b1, 7'b0000011, 1'b1, 1'b1);
        cyc(1'b1, 7'b0000011, 1'b1, 1'b1);
        check("rst_state", state_dbg, ST_FETCH);
        check("rst_en", en(), 5'b00000);

        // lw, zero wait
        cyc(1'b0, 7'b0000011, 1'b1, 1'b0);
        check("lw1_state", state_dbg, ST_FETCH);
        check("lw1_en", en(), 5'b11000);
        check("lw1_sel", {adr_src, alu_src_a, alu_src_b, result_src, alu_op}, {1'b0, 2'b00, 2'b10, 2'b10, 2'b00});
        cyc(1'b0, 7'b0000011, 1'b1, 1'b0);
        check("lw2_state", state_dbg, ST_DECODE);
        check("lw2_sel", {alu_src_a, alu_src_b, alu_op, imm_src}, {2'b01, 2'b01, 2'b00, 2'b00});
        check("lw2_en", en(), 5'b00000);
        cyc(1'b0, 7'b0000011, 1'b1, 1'b0);
        check("lw3_state", state_dbg, ST_MEMADR);
        check("lw3_sel", {alu_src_a, alu_src_b, alu_op}, {2'b10, 2'b01, 2'b00});
        cyc(1'b0, 7'b0000011, 1'b1, 1'b0);
        check("lw4_state", state_dbg, ST_MEMREAD);
        check("lw4_adr", adr_src, 1'b1);
        check("lw4_en", en(), 5'b00000);
        cyc(1'b0, 7'b0000011, 1'b1, 1'b0);
        check("lw5_state", state_dbg, ST_MEMWB);
        check("lw5_en", en(), 5'b00101);
        check("lw5_res", result_src, 2'b01);

        // Fetch stalled 3 cycles, then a taken branch
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 7'b1100011, 1'b0, 1'b1);
            check("stall_state", state_dbg, ST_FETCH);
            check("stall_en", en(), 5'b00000);
        end
        cyc(1'b0, 7'b1100011, 1'b1, 1'b1);
        check("stall_go_en", en(), 5'b11000);
        cyc(1'b0, 7'b1100011, 1'b0, 1'b1);
        check("br_dec_state", state_dbg, ST_DECODE);
        check("br_imm", imm_src, 2'b10);
        cyc(1'b0, 7'b1100011, 1'b0, 1'b1);
        check("brt_state", state_dbg, ST_BRANCH);
        check("brt_en", en(), 5'b10001);
        check("brt_sel", {alu_src_a, alu_src_b, alu_op, result_src}, {2'b10, 2'b00, 2'b01, 2'b00});

        // Branch not taken
        cyc(1'b0, 7'b1100011, 1'b1, 1'b0);
        check("brn_fetch", state_dbg, ST_FETCH);
        cyc(1'b0, 7'b1100011, 1'b1, 1'b0);
        cyc(1'b0, 7'b1100011, 1'b1, 1'b0);
        check("brn_state", state_dbg, ST_BRANCH);
        check("brn_en", en(), 5'b00001);

        // jal: FETCH, DECODE, JAL, ALUWB
        cyc(1'b0, 7'b1101111, 1'b1, 1'b0);
        check("jal1_state", state_dbg, ST_FETCH);
        cyc(1'b0, 7'b1101111, 1'b1, 1'b0);
        check("jal_imm", imm_src, 2'b11);
        cyc(1'b0, 7'b1101111, 1'b1, 1'b0);
        check("jal3_state", state_dbg, ST_JAL);
        check("jal3_en", en(), 5'b10000);
        check("jal3_sel", {alu_src_a, alu_src_b, alu_op}, {2'b01, 2'b10, 2'b00});
        cyc(1'b0, 7'b1101111, 1'b1, 1'b0);
        check("jal4_state", state_dbg, ST_ALUWB);
        check("jal4_en", en(), 5'b00101);
        check("jal4_res", result_src, 2'b00);

        // R-type execute
        cyc(1'b0, 7'b0110011, 1'b1, 1'b0);
        cyc(1'b0, 7'b0110011, 1'b1, 1'b0);
        cyc(1'b0, 7'b0110011, 1'b1, 1'b0);
        check("r3_state", state_dbg, ST_EXECR);
        check("r3_sel", {alu_src_a, alu_src_b, alu_op}, {2'b10, 2'b00, 2'b10});
        cyc(1'b0, 7'b0110011, 1'b1, 1'b0);
        check("r4_state", state_dbg, ST_ALUWB);

        // sw stalled in MEMWRITE, then aborted by a 3-cycle reset
        cyc(1'b0, 7'b0100011, 1'b1, 1'b0);
        check("sw1_state", state_dbg, ST_FETCH);
        cyc(1'b0, 7'b0100011, 1'b1, 1'b0);
        check("sw_imm", imm_src, 2'b01);
        cyc(1'b0, 7'b0100011, 1'b1, 1'b0);
        cyc(1'b0, 7'b0100011, 1'b0, 1'b0);
        check("sw4_state", state_dbg, ST_MEMWRITE);
        check("sw4_en", en(), 5'b00010);
        check("sw4_adr", adr_src, 1'b1);
        cyc(1'b1, 7'b0100011, 1'b1, 1'b0);
        check("swrst_state", state_dbg, ST_MEMWRITE);
        check("swrst_en", en(), 5'b00000);
        cyc(1'b1, 7'b0100011, 1'b1, 1'b0);
        check("swrst2_en", en(), 5'b00000);
        cyc(1'b1, 7'b0100011, 1'b1, 1'b0);
        check("swrst3_state", state_dbg, ST_FETCH);
        cyc(1'b0, 7'b1111111, 1'b1, 1'b0);
        check("post_rst_state", state_dbg, ST_FETCH);
        check("post_rst_en", en(), 5'b11000);

        // Unknown opcode
        cyc(1'b0, 7'b1111111, 1'b1, 1'b0);
        check("ill_dec_state", state_dbg, ST_DECODE);
`ifdef CU_ILLEGAL_TRAP_EN
        check("ill_dec_en", en(), 5'b00000);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 7'b0000011, 1'b1, 1'b1);
            check("ill_state", state_dbg, ST_ILLEGAL);
            check("ill_flag", illegal_instr, 1'b1);
            check("ill_en", en(), 5'b00000);
        end
`else
        check("nop_dec_en", en(), 5'b00001);
        cyc(1'b0, 7'b1111111, 1'b1, 1'b0);
        check("nop_next_state", state_dbg, ST_FETCH);
        check("nop_next_en", en(), 5'b11000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit_main_fsm.md
# control_unit_main_fsm

Multicycle main controller for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables and multiplexer selects, and produces the 2-bit ALU operation class consumed by the ALU decoder directly downstream. A memory-ready handshake lets fetch and data accesses stall for any number of cycles.

## Interface
- No parameters.
- `clk` in 1: single core clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 7: opcode field of the instruction register.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `branch_taken` in 1: branch condition true, computed from ALU flags in the datapath.
- `pc_write` out 1: PC register load enable.
- `ir_write` out 1: instruction register and old-PC register load enable.
- `reg_write` out 1: register file write enable.
- `mem_write` out 1: data memory write strobe.
- `adr_src` out 1: memory address select (0 = PC, 1 = ALU result register).
- `alu_src_a` out 2: ALU source A select (00 PC, 01 old PC, 10 rs1).
- `alu_src_b` out 2: ALU source B select (00 rs2, 01 immediate, 10 constant 4).
- `result_src` out 2: result select (00 ALU register, 01 memory data, 10 ALU output).
- `imm_src` out 2: immediate format (00 I, 01 S, 10 B, 11 J). Combinational from `op`.
- `alu_op` out 2: ALU operation class (00 add, 01 branch, 10 R/I-type), to the ALU decoder.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `illegal_instr` out 1: sticky illegal-opcode flag. Present only with the macro in Configuration.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL. ILLEGAL exists only with the macro.
- Outputs are Moore, decoded from the state. Any signal not listed for a state is 0.
- `pc_write` = pc_update | (branch & `branch_taken`).
- FETCH
  - Drives adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - ir_write=1 and pc_update=1 only in a cycle with `mem_ready`=1.
  - Stays in FETCH until `mem_ready`; then goes to DECODE.
- DECODE: a=01, b=01, alu_op=00, which forms the branch target. `op` is sampled here:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → see Configuration
- MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD if `op`=0000011, otherwise MEMWRITE.
- MEMREAD: adr_src=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Then FETCH.
- MEMWRITE: adr_src=1. mem_write=1 in every cycle of the state. Leaves for FETCH in the first cycle with `mem_ready`=1.
- EXECR: a=10, b=00, alu_op=10. Then ALUWB.
- EXECI: a=10, b=01, alu_op=10. Then ALUWB.
- ALUWB: result_src=00, reg_write=1. Then FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1. Then FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Then ALUWB, which writes the link value.
- `instr_done` is high in the cycles that leave MEMWB, MEMWRITE (with `mem_ready`), ALUWB and BRANCH. In the no-macro build it is also high in DECODE on an unknown opcode.

## Timing
- While `rst`=1: next state is FETCH and every enable output is forced to 0, including pc_write, ir_write, reg_write and mem_write.
- First cycle after `rst` falls: FETCH.
- A reset asserted mid-instruction aborts it at the next edge. No writes occur during the reset cycle.
- Cycles per instruction, with zero-wait memory:
  - lw: 5
  - sw: 4
  - R-type and I-type: 4
  - branch: 3
  - jal: 4
- Each `mem_ready`-low cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_ready` is ignored in every other state.
- `branch_taken` is used only in BRANCH.
- `imm_src` has zero latency from `op`; its default is 00.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to ILLEGAL.
  - ILLEGAL holds forever with all enables 0.
  - `illegal_instr` is set and stays 1 until `rst`.
- Undefined:
  - An unknown opcode executes as a NOP: DECODE goes straight to FETCH.
  - No ILLEGAL state and no `illegal_instr` port.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - ALUOP_ADD/BRANCH/RTYPE
  - the IMM_I/S/B/J encodings
- Sub-module `control_unit_imm_decoder` maps `op` to `imm_src`. Everything else stays in one module: a state register plus next-state and output decode.

## Test plan
- Reset: hold `rst` for 3 cycles mid-MEMWRITE → mem_write=0 during reset; FETCH on the first cycle after release.
- lw (op=0000011), `mem_ready`=1 always → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5 with result_src=01; `instr_done` on cycle 5.
- FETCH with `mem_ready` low for 3 cycles → ir_write and pc_write are 0 for 3 cycles, then exactly one cycle of both =1.
- Branch (op=1100011): `branch_taken`=1 → pc_write=1 in BRANCH with alu_op=01; `branch_taken`=0 → pc_write=0.
- jal (op=1101111) → JAL with pc_write=1 and a=01, b=10; then ALUWB with reg_write=1; 4 cycles total.
- op=1111111:
  - With macro: ILLEGAL, `illegal_instr`=1 held across 10 cycles, all enables 0.
  - Without macro: FETCH follows DECODE, `instr_done` pulses.
